spi_xfer_ctrl: RTL and testbench

Master-side transfer controller for the APB SPI core. It sits directly upstream of the shifter. It turns a one-cycle `send_data` request into a complete 8-bit frame: it asserts `ss`, produces 16 `sclk` edges at the programmed baud rate, and ends the frame with a one-cycle `receive_data` pulse. The shifter uses that pulse to reset its bit counters and expose `data_miso`. The block holds the baud divider, the frame sequencer and the enable/abort logic.

---
 rtl/spi_xfer_ctrl.sv | 161 ++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// Master-side SPI frame sequencer: baud divider, LEAD/XFER/TRAIL framing of
// one 8-bit frame (16 sclk edges), enable gating and abort.
module spi_xfer_ctrl (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       mstr,
   input  logic       spe,
   input  logic       spiswai,
   input  logic [1:0] spi_mode,
   input  logic       cpol,
   input  logic [2:0] sppr,
   input  logic [2:0] spr,
   input  logic       send_data,
   output logic       sclk,
   output logic       ss,
   output logic       receive_data,
   output logic       tip
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEAD  = 2'd1,
      XFER  = 2'd2,
      TRAIL = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [10:0] baud_cnt_q, baud_cnt_d;
   logic [10:0] half_q, half_d;
   logic [10:0] half_s;
   logic [4:0]  edge_cnt_q, edge_cnt_d;
   logic        cpol_q, cpol_d;
   logic        sclk_q, sclk_d;
   logic        ss_q, ss_d;
   logic        tip_q, tip_d;
   logic        rx_q, rx_d;
   logic        en_s;
   logic        tc_s;

   assign en_s   = spe & mstr & ((spi_mode == 2'b00) | ((spi_mode == 2'b01) & ~spiswai));
   // Half period (sppr+1) << spr tops out at 8 << 7 = 1024, so 11 bits suffice.
   assign half_s = ({8'd0, sppr} + 11'd1) << spr;
   assign tc_s   = (baud_cnt_q == (half_q - 11'd1));

   // Next-state and output decode; an enable drop outside IDLE wins over any terminal count.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      edge_cnt_d = edge_cnt_q;
      half_d     = half_q;
      cpol_d     = cpol_q;
      sclk_d     = sclk_q;
      ss_d       = ss_q;
      tip_d      = tip_q;
      rx_d       = 1'b0;

      if ((state_q != IDLE) && !en_s) begin
         state_d    = IDLE;
         baud_cnt_d = 11'd0;
         edge_cnt_d = 5'd0;
         sclk_d     = cpol_q;
         ss_d       = 1'b1;
         tip_d      = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               baud_cnt_d = 11'd0;
               sclk_d     = cpol;
               ss_d       = 1'b1;
               tip_d      = 1'b0;
               if (send_data && en_s) begin
                  state_d    = LEAD;
                  edge_cnt_d = 5'd0;
                  half_d     = half_s;
                  cpol_d     = cpol;
                  ss_d       = 1'b0;
                  tip_d      = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
            LEAD: begin
               if (tc_s) begin
                  state_d    = XFER;
                  baud_cnt_d = 11'd0;
                  edge_cnt_d = 5'd1;
                  sclk_d     = ~cpol_q;
               end else begin
                  baud_cnt_d = baud_cnt_q + 11'd1;
               end
            end
            XFER: begin
               if (tc_s) begin
                  baud_cnt_d = 11'd0;
                  edge_cnt_d = edge_cnt_q + 5'd1;
                  if (edge_cnt_q == 5'd15) begin
                     state_d = TRAIL;
                     sclk_d  = cpol_q;
                  end else begin
                     state_d = XFER;
                     sclk_d  = ~sclk_q;
                  end
               end else begin
                  baud_cnt_d = baud_cnt_q + 11'd1;
               end
            end
            TRAIL: begin
               if (tc_s) begin
                  state_d    = IDLE;
                  baud_cnt_d = 11'd0;
                  edge_cnt_d = 5'd0;
                  ss_d       = 1'b1;
                  tip_d      = 1'b0;
                  rx_d       = 1'b1;
               end else begin
                  baud_cnt_d = baud_cnt_q + 11'd1;
               end
            end
            default: begin
               state_d    = IDLE;
               baud_cnt_d = 11'd0;
               edge_cnt_d = 5'd0;
               sclk_d     = cpol_q;
               ss_d       = 1'b1;
               tip_d      = 1'b0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q    <= IDLE;
         baud_cnt_q <= 11'd0;
         edge_cnt_q <= 5'd0;
         half_q     <= 11'd1;
         cpol_q     <= 1'b0;
         sclk_q     <= 1'b0;
         ss_q       <= 1'b1;
         tip_q      <= 1'b0;
         rx_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         half_q     <= half_d;
         cpol_q     <= cpol_d;
         sclk_q     <= sclk_d;
         ss_q       <= ss_d;
         tip_q      <= tip_d;
         rx_q       <= rx_d;
      end
   end

   assign sclk         = sclk_q;
   assign ss           = ss_q;
   assign receive_data = rx_q;
   assign tip          = tip_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: frame-timing table, directed corner
// sequences and randomized stimulus against a cycle-offset reference model.
module tb_spi_xfer_ctrl;

   logic       PCLK = 1'b0;
   logic       PRESET = 1'b0;
   logic       mstr, spe, spiswai, cpol, send_data;
   logic [1:0] spi_mode;
   logic [2:0] sppr, spr;
   logic       sclk, ss, receive_data, tip;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int rx_cnt = 0;

   spi_xfer_ctrl dut (
      .PCLK(PCLK), .PRESET(PRESET), .mstr(mstr), .spe(spe), .spiswai(spiswai),
      .spi_mode(spi_mode), .cpol(cpol), .sppr(sppr), .spr(spr), .send_data(send_data),
      .sclk(sclk), .ss(ss), .receive_data(receive_data), .tip(tip)
   );

   always #5 PCLK = ~PCLK;

   always @(posedge PCLK) cyc <= cyc + 1;
   always @(posedge PCLK) if (receive_data === 1'b1) rx_cnt <= rx_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a frame is described only by its start cycle, half period
   // and polarity; every output follows from the offset since the start.
   logic m_active = 1'b0;
   int   m_t0 = 0;
   int   m_h = 1;
   logic m_cp = 1'b0;
   logic e_sclk = 1'b0, e_ss = 1'b1, e_tip = 1'b0, e_rx = 1'b0;
   logic ref_en;
   int   ref_hnow, ref_off;

   assign ref_en   = spe & mstr & ((spi_mode == 2'b00) | ((spi_mode == 2'b01) & ~spiswai));
   assign ref_hnow = (int'(sppr) + 1) * (1 << spr);
   assign ref_off  = cyc - m_t0;

   always @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         m_active <= 1'b0;
         e_sclk   <= 1'b0;
         e_ss     <= 1'b1;
         e_tip    <= 1'b0;
         e_rx     <= 1'b0;
      end else begin
         e_rx <= 1'b0;
         if (m_active && !ref_en) begin
            m_active <= 1'b0;
            e_ss     <= 1'b1;
            e_tip    <= 1'b0;
            e_sclk   <= m_cp;
         end else if (m_active) begin
            if (ref_off == 17 * m_h) begin
               m_active <= 1'b0;
               e_ss     <= 1'b1;
               e_tip    <= 1'b0;
               e_rx     <= 1'b1;
               e_sclk   <= m_cp;
            end else begin
               e_ss   <= 1'b0;
               e_tip  <= 1'b1;
               e_sclk <= m_cp ^ (((ref_off / m_h) % 2) == 1);
            end
         end else begin
            e_sclk <= cpol;
            e_ss   <= 1'b1;
            e_tip  <= 1'b0;
            if (send_data && ref_en) begin
               m_active <= 1'b1;
               m_t0     <= cyc;
               m_h      <= ref_hnow;
               m_cp     <= cpol;
               e_ss     <= 1'b0;
               e_tip    <= 1'b1;
            end
         end
      end
   end

   // Continuous cycle-by-cycle comparison against the model.
   always @(negedge PCLK) begin
      check("sclk", sclk, e_sclk);
      check("ss", ss, e_ss);
      check("tip", tip, e_tip);
      check("receive_data", receive_data, e_rx);
   end

   task automatic wait_until(input int target);
      int n;
      n = 0;
      while (cyc < target && n < 5000) begin
         @(negedge PCLK);
         n++;
      end
      check("wait_bound", (cyc >= target), 1'b1);
   endtask

   task automatic wait_rx(input int t0, output int off);
      int n;
      n = 0;
      while (receive_data !== 1'b1 && n < 20000) begin
         @(negedge PCLK);
         n++;
      end
      off = (receive_data === 1'b1) ? (cyc - t0) : -1;
   endtask

   task automatic start_frame(input logic [2:0] p, input logic [2:0] s, input logic cp, output int t0);
      @(negedge PCLK);
      sppr = p; spr = s; cpol = cp;
      @(negedge PCLK);
      send_data = 1'b1;
      t0 = cyc;
      @(negedge PCLK);
      send_data = 1'b0;
   endtask

   typedef struct {
      logic [2:0] sppr;
      logic [2:0] spr;
      logic       cpol;
      int         exp_off;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int t0, t1, off, rc, h;
      mstr = 1'b1; spe = 1'b1; spiswai = 1'b0; spi_mode = 2'b00;
      cpol = 1'b0; sppr = 3'd0; spr = 3'd0; send_data = 1'b0;

      vecs[0] = '{3'd0, 3'd0, 1'b0, 18};
      vecs[1] = '{3'd2, 3'd1, 1'b0, 103};
      vecs[2] = '{3'd0, 3'd0, 1'b1, 18};
      vecs[3] = '{3'd3, 3'd0, 1'b1, 69};
      vecs[4] = '{3'd1, 3'd2, 1'b0, 137};
      vecs[5] = '{3'd7, 3'd3, 1'b1, 1089};

      #1 PRESET = 1'b1;
      repeat (3) @(negedge PCLK);
      #1;
      check("rst_ss", ss, 1'b1);
      check("rst_sclk", sclk, 1'b0);
      check("rst_tip", tip, 1'b0);
      check("rst_rx", receive_data, 1'b0);
      @(negedge PCLK);
      PRESET = 1'b0;
      repeat (2) @(negedge PCLK);

      for (int i = 0; i < 6; i++) begin
         start_frame(vecs[i].sppr, vecs[i].spr, vecs[i].cpol, t0);
         wait_rx(t0, off);
         check("frame_len", off, vecs[i].exp_off);
      end

      // Mid-frame divider change must not affect the running frame.
      start_frame(3'd2, 3'd1, 1'b0, t0);
      wait_until(t0 + 1 + 4 * 6);
      sppr = 3'd7;
      wait_rx(t0, off);
      check("cfg_locked", off, 103);
      sppr = 3'd0; spr = 3'd0;

      // sclk idle level follows cpol one cycle later.
      @(negedge PCLK);
      cpol = 1'b1;
      @(negedge PCLK);
      check("idle_cpol1", sclk, 1'b1);
      cpol = 1'b0;
      @(negedge PCLK);

      // Abort right after edge 5.
      start_frame(3'd1, 3'd0, 1'b0, t0);
      wait_until(t0 + 1 + 5 * 2);
      rc = rx_cnt;
      spe = 1'b0;
      @(negedge PCLK);
      check("abort_ss", ss, 1'b1);
      check("abort_tip", tip, 1'b0);
      check("abort_sclk", sclk, 1'b0);
      repeat (40) @(negedge PCLK);
      check("abort_no_rx", rx_cnt, rc);
      spe = 1'b1;
      start_frame(3'd1, 3'd0, 1'b0, t0);
      wait_rx(t0, off);
      check("post_abort_len", off, 35);

      // Gating: each blocking configuration ignores send_data.
      for (int g = 0; g < 3; g++) begin
         @(negedge PCLK);
         mstr = (g != 0);
         spi_mode = (g == 1) ? 2'b01 : ((g == 2) ? 2'b10 : 2'b00);
         spiswai = (g == 1);
         send_data = 1'b1;
         @(negedge PCLK);
         send_data = 1'b0;
         repeat (3) @(negedge PCLK);
         check("gated_ss", ss, 1'b1);
         check("gated_tip", tip, 1'b0);
      end
      mstr = 1'b1; spi_mode = 2'b00; spiswai = 1'b0;

      // send_data mid-frame is not queued.
      start_frame(3'd1, 3'd0, 1'b0, t0);
      rc = rx_cnt;
      wait_until(t0 + 10);
      send_data = 1'b1;
      @(negedge PCLK);
      send_data = 1'b0;
      wait_rx(t0, off);
      check("midsend_len", off, 35);
      repeat (40) @(negedge PCLK);
      check("midsend_one_rx", rx_cnt - rc, 1);
      check("midsend_idle", ss, 1'b1);

      // Back-to-back: new request on the receive_data cycle.
      start_frame(3'd0, 3'd0, 1'b0, t0);
      wait_rx(t0, off);
      check("b2b_first", off, 18);
      send_data = 1'b1;
      t1 = cyc;
      @(negedge PCLK);
      send_data = 1'b0;
      check("b2b_ss", ss, 1'b0);
      check("b2b_tip", tip, 1'b1);
      wait_rx(t1, off);
      check("b2b_second", off, 18);

      // Reset mid-frame at edge 8.
      start_frame(3'd2, 3'd1, 1'b0, t0);
      wait_until(t0 + 1 + 8 * 6);
      #2 PRESET = 1'b1;
      #1;
      check("rstmid_ss", ss, 1'b1);
      check("rstmid_sclk", sclk, 1'b0);
      check("rstmid_tip", tip, 1'b0);
      check("rstmid_rx", receive_data, 1'b0);
      repeat (2) @(negedge PCLK);
      PRESET = 1'b0;
      start_frame(3'd2, 3'd1, 1'b0, t0);
      wait_rx(t0, off);
      check("rstmid_after", off, 103);

      // Randomized traffic; the model checks every cycle.
      for (int it = 0; it < 25; it++) begin
         start_frame(3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), t0);
         h = ref_hnow;
         for (int c = 0; c < 17 * h + 20; c++) begin
            @(negedge PCLK);
            send_data = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) begin
               sppr = 3'($urandom_range(0, 7));
               spr  = 3'($urandom_range(0, 3));
               cpol = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 299) == 0) spe = 1'b0;
            else if ($urandom_range(0, 3) == 0) spe = 1'b1;
            if ($urandom_range(0, 399) == 0) spi_mode = 2'($urandom_range(0, 3));
            else if ($urandom_range(0, 7) == 0) spi_mode = 2'b00;
         end
         send_data = 1'b0; spe = 1'b1; spi_mode = 2'b00;
      end

      repeat (3) @(negedge PCLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
